// File: rtl/spi_slave_egress_arbiter.sv
// Round-robin arbiter that merges NUM_SRC AXIS byte streams onto one SPI egress stream.
// Each grant has an optional header byte and carries at most MTU_SIZE payload bytes.
module spi_slave_egress_arbiter #(
  parameter int         NUM_SRC   = 2,
  parameter int         MTU_SIZE  = 16,
  parameter int         HEADER_EN = 1,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NUM_SRC-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]   s_axis_tvalid,
  input  logic [NUM_SRC-1:0]   s_axis_tlast,
  output logic [NUM_SRC-1:0]   s_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [7:0]           m_axis_tuser,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 mtu_cut
);

  localparam int         CW         = $clog2(MTU_SIZE + 1);
  localparam logic [2:0] LAST_RST   = 3'(NUM_SRC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MTU_SIZE - 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t        r_state;
  logic [2:0]    r_grant_id;
  logic [2:0]    r_last_grant;
  logic [CW-1:0] r_byte_cnt;
  logic          r_mtu_cut;
  logic          r_busy;

  logic          w_any_vld;
  logic [2:0]    w_winner;
  logic          w_src_vld;
  logic          w_src_last;
  logic [7:0]    w_src_dat;
  logic          w_mtu_hit;
  logic          w_data_last;

  // Scan from the largest offset down so the nearest source after last_grant wins.
  always_comb begin
    w_any_vld = |s_axis_tvalid;
    w_winner  = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (s_axis_tvalid[i] && (i == (int'(r_last_grant) + k) % NUM_SRC)) begin
          w_winner = 3'(i);
        end
      end
    end
  end

  always_comb begin
    w_src_vld  = 1'b0;
    w_src_last = 1'b0;
    w_src_dat  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant_id == 3'(i)) begin
        w_src_vld  = s_axis_tvalid[i];
        w_src_last = s_axis_tlast[i];
        w_src_dat  = s_axis_tdata[8*i +: 8];
      end
    end
    w_mtu_hit   = (r_byte_cnt == CNT_LAST);
    w_data_last = w_src_last | w_mtu_hit;
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = IDLE_BYTE;
    s_axis_tready = '0;
    case (r_state)
      HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {1'b1, r_grant_id, 4'b0000};
      end
      DATA: begin
        m_axis_tvalid = w_src_vld;
        m_axis_tdata  = w_src_dat;
        m_axis_tlast  = w_data_last;
        for (int i = 0; i < NUM_SRC; i++) begin
          s_axis_tready[i] = (r_grant_id == 3'(i)) & m_axis_tready;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= LAST_RST;
      r_byte_cnt   <= '0;
      r_mtu_cut    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_mtu_cut <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_vld) begin
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_byte_cnt   <= '0;
            r_busy       <= 1'b1;
            r_state      <= (HEADER_EN != 0) ? HEADER : DATA;
          end
        end
        HEADER: begin
          if (m_axis_tready) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_src_vld && m_axis_tready) begin
            r_byte_cnt <= r_byte_cnt + CW'(1);
            // A grant closed by the byte limit rather than the source gets flagged.
            if (w_data_last) begin
              r_state   <= IDLE;
              r_busy    <= 1'b0;
              r_mtu_cut <= ~w_src_last;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tuser = IDLE_BYTE;
  assign grant_id     = r_grant_id;
  assign busy         = r_busy;
  assign mtu_cut      = r_mtu_cut;

endmodule

// File: tb/tb_spi_slave_egress_arbiter.sv
// Bench for spi_slave_egress_arbiter: two instances (2 src/MTU4/header, 3 src/MTU5/no header)
// scored against a packet-level model of grants, headers and MTU cuts.
module tb_spi_slave_egress_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  bit          sel;
  logic [23:0] t_tdata;
  logic [2:0]  t_tvalid, t_tlast;
  logic        t_mrdy;

  logic [15:0] a_tdata;
  logic [1:0]  a_tvalid, a_tlast, a_stready;
  logic [7:0]  a_mdata, a_muser;
  logic        a_mvld, a_mlast, a_mrdy, a_busy, a_cut;
  logic [2:0]  a_gid;

  logic [23:0] b_tdata;
  logic [2:0]  b_tvalid, b_tlast, b_stready;
  logic [7:0]  b_mdata, b_muser;
  logic        b_mvld, b_mlast, b_mrdy, b_busy, b_cut;
  logic [2:0]  b_gid;

  logic [2:0]  o_stready, o_gid;
  logic [7:0]  o_mdata, o_muser;
  logic        o_mvld, o_mlast, o_busy, o_cut;

  assign a_tdata  = sel ? 16'h0 : t_tdata[15:0];
  assign a_tvalid = sel ? 2'b0  : t_tvalid[1:0];
  assign a_tlast  = sel ? 2'b0  : t_tlast[1:0];
  assign a_mrdy   = sel ? 1'b0  : t_mrdy;
  assign b_tdata  = sel ? t_tdata  : 24'h0;
  assign b_tvalid = sel ? t_tvalid : 3'b0;
  assign b_tlast  = sel ? t_tlast  : 3'b0;
  assign b_mrdy   = sel ? t_mrdy   : 1'b0;

  assign o_stready = sel ? b_stready : {1'b0, a_stready};
  assign o_mdata   = sel ? b_mdata : a_mdata;
  assign o_muser   = sel ? b_muser : a_muser;
  assign o_mvld    = sel ? b_mvld  : a_mvld;
  assign o_mlast   = sel ? b_mlast : a_mlast;
  assign o_gid     = sel ? b_gid   : a_gid;
  assign o_busy    = sel ? b_busy  : a_busy;
  assign o_cut     = sel ? b_cut   : a_cut;

  spi_slave_egress_arbiter #(.NUM_SRC(2), .MTU_SIZE(4), .HEADER_EN(1), .IDLE_BYTE(8'hFF)) u_dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tlast(a_tlast), .s_axis_tready(a_stready),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvld), .m_axis_tready(a_mrdy), .m_axis_tlast(a_mlast),
    .m_axis_tuser(a_muser), .grant_id(a_gid), .busy(a_busy), .mtu_cut(a_cut)
  );

  spi_slave_egress_arbiter #(.NUM_SRC(3), .MTU_SIZE(5), .HEADER_EN(0), .IDLE_BYTE(8'h5A)) u_dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast), .s_axis_tready(b_stready),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvld), .m_axis_tready(b_mrdy), .m_axis_tlast(b_mlast),
    .m_axis_tuser(b_muser), .grant_id(b_gid), .busy(b_busy), .mtu_cut(b_cut)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [2:0] g;
    logic       c;
    logic       h;
  } exp_t;

  int         tests_run;
  int         tests_failed;
  exp_t       expq[$];
  logic [8:0] strm [3][64];
  int         slen [3];
  int         dptr [3];

  task automatic clear_streams();
    for (int s = 0; s < 3; s++) begin
      slen[s] = 0;
      dptr[s] = 0;
    end
  endtask

  task automatic push_byte(input int s, input logic [7:0] d, input logic l);
    strm[s][slen[s]] = {l, d};
    slen[s]++;
  endtask

  task automatic add_rand_pkt(input int s, input int n);
    for (int i = 0; i < n; i++) push_byte(s, 8'($urandom), (i == n - 1));
  endtask

  // Expected egress stream: walk the grants round-robin over sources with bytes left,
  // emit a header, then up to mtu bytes stopping at the source's end of packet.
  task automatic build_model(input int mtu, input bit hdr, input int ns);
    int ptr [3];
    int last, w, s, cnt;
    logic [8:0] b;
    exp_t e;
    bit lim;
    expq.delete();
    for (int i = 0; i < 3; i++) ptr[i] = 0;
    last = ns - 1;
    while (1) begin
      w = -1;
      for (int k = ns; k >= 1; k--) begin
        s = (last + k) % ns;
        if (ptr[s] < slen[s]) w = s;
      end
      if (w < 0) break;
      last = w;
      if (hdr) begin
        e.d = 8'h80 + 8'(w * 16); e.l = 1'b0; e.g = 3'(w); e.c = 1'b0; e.h = 1'b1;
        expq.push_back(e);
      end
      cnt = 0;
      while (1) begin
        b = strm[w][ptr[w]];
        ptr[w]++;
        cnt++;
        lim = (cnt == mtu);
        e.d = b[7:0]; e.l = b[8] | lim; e.g = 3'(w); e.c = lim & ~b[8]; e.h = 1'b0;
        expq.push_back(e);
        if (e.l || ptr[w] >= slen[w]) break;
      end
    end
  endtask

  task automatic drive_and_score(input bit do_rst, input int mtu, input bit hdr, input int ns,
                                 input int rdy_mode, input bit gaps, input int abort_after,
                                 input string name);
    int idx, ncyc, tail;
    bit pend, done, bad;
    exp_t e;
    logic [2:0] want_rdy;
    logic [7:0] idle;
    idle = sel ? 8'h5A : 8'hFF;
    build_model(mtu, hdr, ns);
    if (do_rst) begin
      t_tvalid = '0; t_tlast = '0; t_mrdy = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
    t_mrdy = 1'b1; idx = 0; ncyc = 0; tail = 0; pend = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (abort_after >= 0 && idx == abort_after) begin
        rst = 1'b1;
        #1;
        tests_run++;
        if ({o_busy, o_cut, o_mvld, o_mlast, o_stready, o_gid, o_mdata} !== {10'b0, idle}) begin
          tests_failed++;
          $display("FAIL %s reset_outputs: got busy=%b cut=%b vld=%b last=%b srdy=%b gid=%0d dat=%h want all 0, dat=%h",
                   name, o_busy, o_cut, o_mvld, o_mlast, o_stready, o_gid, o_mdata, idle);
        end
        return;
      end
      if (rdy_mode == 1) t_mrdy = ~t_mrdy;
      else if (rdy_mode == 2) t_mrdy = ($urandom_range(0, 3) != 0);
      else t_mrdy = 1'b1;
      for (int s = 0; s < 3; s++) begin
        if (s < ns && dptr[s] < slen[s]) begin
          t_tvalid[s]      = !(gaps && $urandom_range(0, 2) == 0);
          t_tdata[8*s +: 8] = strm[s][dptr[s]][7:0];
          t_tlast[s]       = strm[s][dptr[s]][8];
        end else begin
          t_tvalid[s]      = 1'b0;
          t_tdata[8*s +: 8] = 8'($urandom);
          t_tlast[s]       = 1'b0;
        end
      end
      #1;
      tests_run++;
      if (o_cut !== pend) begin
        tests_failed++;
        $display("FAIL %s mtu_cut@byte%0d: got %b want %b", name, idx, o_cut, pend);
      end
      pend = 1'b0;
      if (o_mvld && idx < expq.size()) begin
        e = expq[idx];
        want_rdy = (e.h || !t_mrdy) ? 3'b000 : (3'b001 << e.g);
        tests_run++;
        if (o_stready !== want_rdy) begin
          tests_failed++;
          $display("FAIL %s s_tready@byte%0d: got %b want %b", name, idx, o_stready, want_rdy);
        end
      end
      if (o_mvld && t_mrdy) begin
        tests_run++;
        if (idx >= expq.size()) begin
          tests_failed++;
          $display("FAIL %s extra_byte: got %h want no transfer", name, o_mdata);
        end else begin
          e = expq[idx];
          if ({o_mdata, o_mlast, o_gid, o_busy, o_muser} !== {e.d, e.l, e.g, 1'b1, idle}) begin
            tests_failed++;
            $display("FAIL %s byte%0d: got dat=%h last=%b gid=%0d busy=%b user=%h want dat=%h last=%b gid=%0d busy=1 user=%h",
                     name, idx, o_mdata, o_mlast, o_gid, o_busy, o_muser, e.d, e.l, e.g, idle);
          end
          pend = e.c;
          idx++;
        end
      end
      for (int s = 0; s < 3; s++) if (t_tvalid[s] && o_stready[s]) dptr[s]++;
      if (idx == expq.size()) tail++;
      if (tail == 2) done = 1'b1;
      ncyc++;
      if (ncyc > 4000) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s timeout: got %0d bytes want %0d", name, idx, expq.size());
        done = 1'b1;
      end
    end
    bad = (idx != expq.size());
    for (int s = 0; s < 3; s++) if (dptr[s] != slen[s]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL %s completion: got %0d bytes (src consumed %0d/%0d/%0d) want %0d (%0d/%0d/%0d)",
               name, idx, dptr[0], dptr[1], dptr[2], expq.size(), slen[0], slen[1], slen[2]);
    end
  endtask

  task automatic test_reset();
    logic [7:0] idle;
    rst = 1'b1; t_tvalid = 3'b111; t_tlast = 3'b111; t_mrdy = 1'b1; t_tdata = 24'h123456;
    for (int i = 0; i < 2; i++) begin
      sel = (i == 1);
      idle = sel ? 8'h5A : 8'hFF;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if ({o_busy, o_cut, o_mvld, o_mlast, o_stready, o_gid, o_mdata, o_muser} !== {10'b0, idle, idle}) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d: got busy=%b cut=%b vld=%b last=%b srdy=%b gid=%0d dat=%h user=%h want zeros, dat/user=%h",
                 i, o_busy, o_cut, o_mvld, o_mlast, o_stready, o_gid, o_mdata, o_muser, idle);
      end
    end
    t_tvalid = '0; t_tlast = '0;
  endtask

  task automatic test_single_packet();
    sel = 1'b0; clear_streams();
    push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h33, 1'b1);
    drive_and_score(1'b1, 4, 1'b1, 2, 0, 1'b0, -1, "single_packet");
  endtask

  task automatic test_round_robin();
    sel = 1'b0; clear_streams();
    for (int p = 0; p < 4; p++) begin
      add_rand_pkt(0, 2);
      add_rand_pkt(1, 2);
    end
    drive_and_score(1'b1, 4, 1'b1, 2, 0, 1'b0, -1, "round_robin");
  endtask

  task automatic test_mtu_cut();
    sel = 1'b0; clear_streams();
    for (int i = 0; i < 6; i++) push_byte(1, 8'hB0 + 8'(i), (i == 5));
    drive_and_score(1'b1, 4, 1'b1, 2, 0, 1'b0, -1, "mtu_cut");
  endtask

  task automatic test_backpressure();
    sel = 1'b0; clear_streams();
    for (int p = 0; p < 3; p++) begin
      add_rand_pkt(0, $urandom_range(1, 7));
      add_rand_pkt(1, $urandom_range(1, 7));
    end
    drive_and_score(1'b1, 4, 1'b1, 2, 1, 1'b0, -1, "backpressure_toggle");
  endtask

  task automatic test_valid_gaps();
    int s;
    sel = 1'b0; clear_streams();
    s = $urandom_range(0, 1);
    for (int p = 0; p < 3; p++) add_rand_pkt(s, $urandom_range(1, 9));
    drive_and_score(1'b1, 4, 1'b1, 2, 2, 1'b1, -1, "valid_gaps");
  endtask

  task automatic test_reset_mid_packet();
    sel = 1'b0; clear_streams();
    for (int i = 0; i < 5; i++) push_byte(0, 8'hC0 + 8'(i), (i == 4));
    drive_and_score(1'b1, 16, 1'b1, 2, 0, 1'b0, 3, "reset_mid_packet");
    clear_streams();
    t_tvalid = '0; t_tlast = '0;
    @(negedge clk);
    rst = 1'b0;
    push_byte(1, 8'hD1, 1'b0); push_byte(1, 8'hD2, 1'b1);
    drive_and_score(1'b0, 4, 1'b1, 2, 0, 1'b0, -1, "after_reset_src1");
  endtask

  task automatic test_no_header();
    sel = 1'b1; clear_streams();
    push_byte(0, 8'hAA, 1'b1);
    drive_and_score(1'b1, 5, 1'b0, 3, 0, 1'b0, -1, "no_header");
  endtask

  task automatic test_random();
    int ns, mtu, maxlen;
    for (int it = 0; it < 6; it++) begin
      sel = it[0];
      ns = sel ? 3 : 2;
      mtu = sel ? 5 : 4;
      maxlen = sel ? 12 : 7;
      clear_streams();
      for (int s = 0; s < ns; s++) begin
        for (int p = $urandom_range(0, 3); p > 0; p--) add_rand_pkt(s, $urandom_range(1, maxlen));
      end
      if (slen[0] == 0) add_rand_pkt(0, $urandom_range(1, maxlen));
      drive_and_score(1'b1, mtu, !sel, ns, 2, 1'b0, -1, sel ? "random_3src" : "random_2src");
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion want $finish before 3ms");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    sel = 1'b0; rst = 1'b1;
    t_tdata = '0; t_tvalid = '0; t_tlast = '0; t_mrdy = 1'b0;
    clear_streams();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_mtu_cut();
    test_backpressure();
    test_valid_gaps();
    test_reset_mid_packet();
    test_no_header();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
